sha3_digest_axis_tx: RTL

// - Output end of the SHA3 AXI-Stream path. Captures the 1600-bit Keccak state from keccak_xor once the

---
 rtl/sha3_axi_pkg.sv | 36 +++
 rtl/sha3_digest_axis_tx_if.sv | 28 ++
 rtl/sha3_digest_word_mux.sv | 44 ++++
 rtl/sha3_digest_axis_tx.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/sha3_axi_pkg.sv
// Shared types and digest-size helpers for the SHA3 AXI-Stream datapath.
package sha3_axi_pkg;

    localparam int unsigned WORD_CNT_W = 6;
    localparam int unsigned NB_W       = 7;

    typedef enum logic [1:0] {
        SHA3_224 = 2'd0,
        SHA3_256 = 2'd1,
        SHA3_384 = 2'd2,
        SHA3_512 = 2'd3
    } sha3_mode_t;

    typedef logic [4:0][4:0][63:0] keccak_state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } tx_state_t;

    function automatic logic [NB_W-1:0] digest_bytes(input sha3_mode_t mode);
        case (mode)
            SHA3_224: return 7'd28;
            SHA3_256: return 7'd32;
            SHA3_384: return 7'd48;
            default:  return 7'd64;
        endcase
    endfunction

    // Beats needed for the digest at bpw bytes per beat (ceiling division).
    function automatic logic [NB_W-1:0] digest_words(input sha3_mode_t mode, input int unsigned bpw);
        return NB_W'((32'(digest_bytes(mode)) + bpw - 32'd1) / bpw);
    endfunction

endpackage

// File: rtl/sha3_digest_axis_tx_if.sv
// AXI-Stream bundle carrying the serialized digest.
interface sha3_digest_axis_tx_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ID_WIDTH   = 8,
    parameter int unsigned DEST_WIDTH = 8
);
    localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;

    logic                  TREADY;
    logic                  TVALID;
    logic [DATA_WIDTH-1:0] TDATA;
    logic [KEEP_WIDTH-1:0] TKEEP;
    logic [KEEP_WIDTH-1:0] TSTRB;
    logic                  TLAST;
    logic [ID_WIDTH-1:0]   TID;
    logic [DEST_WIDTH-1:0] TDEST;
    logic [1:0]            TUSER;

    modport master (
        input  TREADY,
        output TVALID, TDATA, TKEEP, TSTRB, TLAST, TID, TDEST, TUSER
    );

    modport slave (
        output TREADY,
        input  TVALID, TDATA, TKEEP, TSTRB, TLAST, TID, TDEST, TUSER
    );
endinterface

// File: rtl/sha3_digest_word_mux.sv
// Combinational selection of one digest beat (bytes, keep mask, last flag) from a Keccak state.
module sha3_digest_word_mux
    import sha3_axi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  keccak_state_t           state,
    input  logic [WORD_CNT_W-1:0]   word_cnt,
    input  sha3_mode_t              mode,
    output logic [DATA_WIDTH-1:0]   data_c,
    output logic [DATA_WIDTH/8-1:0] keep_c,
    output logic                    last_c
);
    localparam int unsigned BPW = DATA_WIDTH / 8;

    logic [511:0]    digest_flat;
    logic [NB_W-1:0] nb_c;
    logic [NB_W-1:0] nw_c;
    logic [9:0]      byte_idx;

    // Only lanes 0..7 ever hold digest bytes; the rest of the state is deliberately ignored.
    logic unused_lanes;
    assign unused_lanes = ^{state[4], state[3], state[2], state[1][4], state[1][3]};

    assign digest_flat = {state[1][2], state[1][1], state[1][0],
                          state[0][4], state[0][3], state[0][2], state[0][1], state[0][0]};

    always_comb begin
        nb_c     = digest_bytes(mode);
        nw_c     = digest_words(mode, BPW);
        data_c   = '0;
        keep_c   = '0;
        byte_idx = '0;
        for (int j = 0; j < int'(BPW); j++) begin
            byte_idx = 10'(word_cnt) * 10'(BPW) + 10'(j);
            if (byte_idx < {3'b000, nb_c}) begin
                keep_c[j]         = 1'b1;
                data_c[8*j +: 8]  = digest_flat[{byte_idx[5:0], 3'b000} +: 8];
            end
        end
        last_c = ({1'b0, word_cnt} == (nw_c - 7'd1));
    end

endmodule

// File: rtl/sha3_digest_axis_tx.sv
// Captures the final Keccak state and streams the mode-selected digest out as AXI-Stream beats.
module sha3_digest_axis_tx
    import sha3_axi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ID_WIDTH   = 8,
    parameter int unsigned DEST_WIDTH = 8
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  keccak_state_t         state_i,
    input  logic                  state_valid_i,
    output logic                  state_ready_o,
    input  logic [1:0]            mode_i,
    input  logic [ID_WIDTH-1:0]   id_i,
    input  logic [DEST_WIDTH-1:0] dest_i,
    sha3_digest_axis_tx_if.master axis,
    output logic                  busy_o,
    output logic                  done_o
);
    localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;

    if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_width
        $error("sha3_digest_axis_tx: DATA_WIDTH must be 8, 16, 32 or 64");
    end

    tx_state_t             state_q, state_d;
    logic [WORD_CNT_W-1:0] word_cnt_q, word_cnt_d;
    keccak_state_t         cap_state_q;
    sha3_mode_t            cap_mode_q;

    logic                  capture_c, load_c, clear_c, xfer_c;
    keccak_state_t         mux_state_c;
    sha3_mode_t            mux_mode_c;
    logic [WORD_CNT_W-1:0] mux_cnt_c;
    logic [DATA_WIDTH-1:0] mux_data_c;
    logic [KEEP_WIDTH-1:0] mux_keep_c;
    logic                  mux_last_c;

    assign xfer_c = axis.TVALID && axis.TREADY;

    // In IDLE the mux looks at the live inputs so beat 0 is ready on the capture edge.
    always_comb begin
        mux_state_c = (state_q == IDLE) ? state_i : cap_state_q;
        mux_mode_c  = (state_q == IDLE) ? sha3_mode_t'(mode_i) : cap_mode_q;
        mux_cnt_c   = (state_q == IDLE) ? '0 : word_cnt_q + 6'd1;
    end

    sha3_digest_word_mux #(.DATA_WIDTH(DATA_WIDTH)) u_word_mux (
        .state    (mux_state_c),
        .word_cnt (mux_cnt_c),
        .mode     (mux_mode_c),
        .data_c   (mux_data_c),
        .keep_c   (mux_keep_c),
        .last_c   (mux_last_c)
    );

    // Next-state and datapath control.
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        capture_c  = 1'b0;
        load_c     = 1'b0;
        clear_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (state_valid_i) begin
                    capture_c  = 1'b1;
                    load_c     = 1'b1;
                    word_cnt_d = '0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (xfer_c) begin
                    if (axis.TLAST) begin
                        clear_c    = 1'b1;
                        word_cnt_d = '0;
                        state_d    = DONE;
                    end else begin
                        load_c     = 1'b1;
                        word_cnt_d = word_cnt_q + 6'd1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register and state-decoded handshake/status outputs.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q       <= IDLE;
            word_cnt_q    <= '0;
            state_ready_o <= 1'b1;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            axis.TVALID   <= 1'b0;
        end else begin
            state_q       <= state_d;
            word_cnt_q    <= word_cnt_d;
            state_ready_o <= (state_d == IDLE);
            busy_o        <= (state_d == SEND);
            done_o        <= (state_d == DONE);
            axis.TVALID   <= (state_d == SEND);
        end
    end

    // Capture register and beat payload; payload only moves on capture or handshake.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            cap_state_q <= '0;
            cap_mode_q  <= SHA3_224;
            axis.TDATA  <= '0;
            axis.TKEEP  <= '0;
            axis.TSTRB  <= '0;
            axis.TLAST  <= 1'b0;
            axis.TID    <= '0;
            axis.TDEST  <= '0;
            axis.TUSER  <= '0;
        end else begin
            if (capture_c) begin
                cap_state_q <= state_i;
                cap_mode_q  <= sha3_mode_t'(mode_i);
                axis.TID    <= id_i;
                axis.TDEST  <= dest_i;
                axis.TUSER  <= mode_i;
            end
            if (load_c) begin
                axis.TDATA <= mux_data_c;
                axis.TKEEP <= mux_keep_c;
                axis.TSTRB <= mux_keep_c;
                axis.TLAST <= mux_last_c;
            end else if (clear_c) begin
                axis.TDATA <= '0;
                axis.TKEEP <= '0;
                axis.TSTRB <= '0;
                axis.TLAST <= 1'b0;
            end
        end
    end

endmodule
